cdb_broadcaster: RTL and testbench
==================================

# cdb_broadcaster

Common Data Bus (CDB) producer for the Tomasulo-style RISC-V core: collects completed results from the functional units and drives the single CDB that the dispatch unit, register status table, tag FIFO and register file consume. Each functional unit pushes results into its own small result buffer through a valid/ready handshake. A round-robin arbiter selects at most one buffered result per cycle and drives it onto registered CDB outputs.

## Interface
- NUM_FU, 4, functional-unit ports (0 int, 1 mul, 2 div, 3 load/store)
- DATA_WIDTH, 32, result width
- TAG_WIDTH, 7, CDB tag width
- BUF_DEPTH, 2, entries per port result buffer (power of two)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low
- flush  in  1  synchronous discard of all buffered results
- fu_valid  in  NUM_FU  result offered by FU i
- fu_ready  out  NUM_FU  buffer i accepts this cycle
- fu_tag  in  NUM_FU*TAG_WIDTH  tag of FU i, slice i
- fu_data  in  NUM_FU*DATA_WIDTH  result of FU i, slice i
- fu_branch  in  NUM_FU  result is a resolved branch
- fu_branch_taken  in  NUM_FU  branch outcome
- CDB_valid  out  1  broadcast valid
- CDB_tag  out  TAG_WIDTH  broadcast tag
- CDB_data  out  DATA_WIDTH  broadcast data
- CDB_branch  out  1  broadcast is a branch
- CDB_branch_taken  out  1  branch taken

## Operation
- Push: fu_valid[i] & fu_ready[i] at an edge writes {tag, data, branch, branch_taken & branch} to buffer i. Stored taken is always masked by branch.
- fu_ready[i] = (count_i < BUF_DEPTH) & ~flush & reset. It depends only on registered count, so a full buffer does not accept even in a cycle when it is being popped.
- Arbitration (combinational): among non-empty buffers, grant the first index at or after rr_ptr, wrapping modulo NUM_FU. With no buffer non-empty, there is no grant.
- On grant g: pop head of buffer g. CDB registers load head fields, CDB_valid <= 1, rr_ptr <= (g+1) mod NUM_FU.
- No grant: CDB_valid <= 0. CDB_tag, CDB_data, CDB_branch and CDB_branch_taken hold their previous values. Consumers qualify on CDB_valid.
- Buffers are FIFO per port. Results from one FU broadcast in push order. There is no ordering guarantee across FUs.
- Simultaneous push and pop on the same buffer (count < BUF_DEPTH) leaves count unchanged. Pointers wrap modulo BUF_DEPTH.
- flush = 1 in cycle N:
  - all counts <= 0;
  - pushes in cycle N are dropped (ready forced 0);
  - there is no grant, so CDB_valid = 0 in cycle N+1;
  - any result already on the CDB during cycle N stands;
  - rr_ptr is unchanged.
- reset = 0: counts, pointers and rr_ptr <= 0, and every CDB output <= 0. fu_ready = 0 while reset is asserted. Reset mid-operation discards all buffered results without broadcasting them.

## Timing
- A handshake in cycle N appears on the CDB in cycle N+2 at the earliest (buffer write at end of N, arbitration in N+1, CDB register load at end of N+1).
- Throughput: one broadcast per cycle whenever any buffer is non-empty. There are no bubbles between back-to-back grants.
- Each CDB_valid pulse lasts exactly one cycle per result. There is no duplication and no loss except by flush or reset.
- Fairness: with all ports continuously non-empty, each port is granted once every NUM_FU cycles.
- Reset values: CDB_valid, CDB_tag, CDB_data, CDB_branch and CDB_branch_taken are 0; fu_ready is 0 during reset and all 1s in the first cycle after release.

## Structure
- Package cdb_pkg:
  - TAG_WIDTH, DATA_WIDTH, NUM_FU;
  - FU index constants FU_INT=0, FU_MUL=1, FU_DIV=2, FU_LS=3;
  - packed cdb_entry_t {tag, data, branch, branch_taken}.
- Sub-module cdb_result_buffer: BUF_DEPTH-entry FIFO of cdb_entry_t with push, pop, flush, count and ready. It is instantiated NUM_FU times.
- Top level contains the round-robin arbiter, rr_ptr and the CDB output registers.

## Test plan
- Reset: hold reset=0 two cycles. Required: all CDB outputs 0 and fu_ready=4'b0000; after release, fu_ready=4'b1111 and CDB_valid=0.
- Single result: port 1 pushes tag 7'h05, data 32'hDEADBEEF in cycle 0. Required: CDB_valid=1 with tag 7'h05 and data 32'hDEADBEEF in cycle 2 only.
- Round-robin: all four ports push tags 7'h10..7'h13 in the same cycle with rr_ptr=0. Required: CDB tags 7'h10, 7'h11, 7'h12, 7'h13 in cycles 2–5 with no gaps.
- Backpressure: all ports push every cycle for 20 cycles.
  - Each fu_ready drops to 0 once its buffer is full.
  - Every accepted tag is broadcast exactly once, in per-port order.
  - The steady-state grant pattern is 0, 1, 2, 3 repeating.
- Branch: port 3 pushes tag 7'h12 with branch=1, taken=1. Required: CDB_branch=1 and CDB_branch_taken=1. Then port 0 pushes branch=0, taken=1. Required: CDB_branch=0 and CDB_branch_taken=0.
- Flush: three buffers non-empty, with a result on the CDB during cycle N and flush=1 in cycle N. Required:
  - the cycle-N broadcast is unchanged;
  - CDB_valid=0 in cycle N+1 and thereafter until new pushes;
  - pushes offered in cycle N are not accepted.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared widths, functional-unit indices and the CDB entry layout for the
// result broadcaster and its per-port buffers.
package cdb_pkg;
  localparam int NUM_FU     = 4;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 7;

  localparam int FU_INT = 0;
  localparam int FU_MUL = 1;
  localparam int FU_DIV = 2;
  localparam int FU_LS  = 3;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
    logic                  branch;
    logic                  branch_taken;
  } cdb_entry_t;

  localparam int ENTRY_W = $bits(cdb_entry_t);
endpackage

// File: rtl/cdb_result_buffer.sv
// Per-FU result FIFO. Ready looks only at the registered count, so a full
// buffer refuses a push even in the cycle it is being popped.
module cdb_result_buffer
  import cdb_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  localparam int CW = $clog2(BUF_DEPTH + 1),
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_entry,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic [CW-1:0]      count,
  output logic               ready
);
  logic [ENTRY_W-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic               do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready   = (count < CW'(BUF_DEPTH)) & ~flush & reset;
  assign do_push = push & ready;
  assign do_pop  = pop & (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Flush rewinds both pointers as well as the count so the FIFO stays coherent.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/cdb_broadcaster.sv
// Common Data Bus producer: per-FU result buffers, a round-robin arbiter and
// the registered CDB outputs.
module cdb_broadcaster #(
  parameter int NUM_FU     = cdb_pkg::NUM_FU,
  parameter int DATA_WIDTH = cdb_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH  = cdb_pkg::TAG_WIDTH,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_FU-1:0]            fu_valid,
  output logic [NUM_FU-1:0]            fu_ready,
  input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_WIDTH-1:0] fu_data,
  input  logic [NUM_FU-1:0]            fu_branch,
  input  logic [NUM_FU-1:0]            fu_branch_taken,
  output logic                         CDB_valid,
  output logic [TAG_WIDTH-1:0]         CDB_tag,
  output logic [DATA_WIDTH-1:0]        CDB_data,
  output logic                         CDB_branch,
  output logic                         CDB_branch_taken
);
  import cdb_pkg::*;

  localparam int PTRW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CW   = $clog2(BUF_DEPTH + 1);

  logic [NUM_FU-1:0]              pop, nonempty;
  logic [NUM_FU-1:0][ENTRY_W-1:0] head;
  logic [NUM_FU-1:0][CW-1:0]      count;
  logic [PTRW-1:0]                rr_ptr, gnt;
  logic                           gnt_vld;
  int                             idx;
  cdb_entry_t                     win;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_port
    cdb_entry_t in_e;
    assign in_e.tag          = fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
    assign in_e.data         = fu_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign in_e.branch       = fu_branch[i];
    assign in_e.branch_taken = fu_branch_taken[i] & fu_branch[i];
    assign nonempty[i]       = (count[i] != '0);
    assign pop[i]            = gnt_vld && (gnt == PTRW'(i));

    cdb_result_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .push       (fu_valid[i]),
      .push_entry (in_e),
      .pop        (pop[i]),
      .head       (head[i]),
      .count      (count[i]),
      .ready      (fu_ready[i])
    );
  end

  // First non-empty port at or after rr_ptr; flush suppresses the grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_FU;
      if (!gnt_vld && nonempty[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx[PTRW-1:0];
      end
    end
    if (flush) gnt_vld = 1'b0;
  end

  assign win = cdb_entry_t'(head[gnt]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      CDB_valid        <= 1'b0;
      CDB_tag          <= '0;
      CDB_data         <= '0;
      CDB_branch       <= 1'b0;
      CDB_branch_taken <= 1'b0;
      rr_ptr           <= '0;
    end else begin
      CDB_valid <= gnt_vld;
      if (gnt_vld) begin
        CDB_tag          <= win.tag;
        CDB_data         <= win.data;
        CDB_branch       <= win.branch;
        CDB_branch_taken <= win.branch_taken;
        rr_ptr           <= (gnt == PTRW'(NUM_FU - 1)) ? '0 : gnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboarded bench for cdb_broadcaster: accepted pushes are queued per port
// and matched against each CDB broadcast; directed checks cover timing.
module tb_cdb_broadcaster;
  logic         clk = 1'b0;
  logic         reset, flush;
  logic [3:0]   fu_valid, fu_ready, fu_branch, fu_branch_taken;
  logic [27:0]  fu_tag;
  logic [127:0] fu_data;
  logic         CDB_valid, CDB_branch, CDB_branch_taken;
  logic [6:0]   CDB_tag;
  logic [31:0]  CDB_data;

  cdb_broadcaster dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .fu_valid         (fu_valid),
    .fu_ready         (fu_ready),
    .fu_tag           (fu_tag),
    .fu_data          (fu_data),
    .fu_branch        (fu_branch),
    .fu_branch_taken  (fu_branch_taken),
    .CDB_valid        (CDB_valid),
    .CDB_tag          (CDB_tag),
    .CDB_data         (CDB_data),
    .CDB_branch       (CDB_branch),
    .CDB_branch_taken (CDB_branch_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  tag;
    logic [31:0] data;
    logic        br;
    logic        tk;
  } exp_t;

  exp_t sb[4][$];
  int   nvec = 0, nerr = 0;
  int   n[4];
  bit   full[4];
  int   lastp;
  int   p;
  exp_t e;

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", t, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input logic [6:0] t, input logic [31:0] d,
                     input logic b, input logic tk);
    fu_valid[i]          = 1'b1;
    fu_tag[i*7 +: 7]     = t;
    fu_data[i*32 +: 32]  = d;
    fu_branch[i]         = b;
    fu_branch_taken[i]   = tk;
  endtask

  // Scoreboard: check broadcasts against queue heads, then record handshakes.
  always @(negedge clk) begin
    if (CDB_valid === 1'b1) begin
      p = -1;
      for (int i = 0; i < 4; i++)
        if (p < 0 && sb[i].size() > 0 && sb[i][0].tag == CDB_tag) p = i;
      chk("cdb_known_tag", 64'(p >= 0), 64'd1);
      if (p >= 0) begin
        chk("cdb_data", 64'(CDB_data), 64'(sb[p][0].data));
        chk("cdb_branch", 64'(CDB_branch), 64'(sb[p][0].br));
        chk("cdb_taken", 64'(CDB_branch_taken), 64'(sb[p][0].tk));
        void'(sb[p].pop_front());
      end
    end
    if (reset !== 1'b1 || flush === 1'b1) begin
      for (int i = 0; i < 4; i++) sb[i].delete();
    end else begin
      for (int i = 0; i < 4; i++)
        if (fu_valid[i] && fu_ready[i] === 1'b1) begin
          e.tag  = fu_tag[i*7 +: 7];
          e.data = fu_data[i*32 +: 32];
          e.br   = fu_branch[i];
          e.tk   = fu_branch[i] & fu_branch_taken[i];
          sb[i].push_back(e);
        end
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; fu_valid = '0; fu_tag = '0; fu_data = '0;
    fu_branch = '0; fu_branch_taken = '0;

    // reset
    nxt(); nxt(); @(negedge clk);
    chk("rst_ready", 64'(fu_ready), 64'h0);
    chk("rst_valid", 64'(CDB_valid), 64'h0);
    chk("rst_tag", 64'(CDB_tag), 64'h0);
    chk("rst_data", 64'(CDB_data), 64'h0);
    chk("rst_branch", 64'(CDB_branch), 64'h0);
    chk("rst_taken", 64'(CDB_branch_taken), 64'h0);
    nxt(); reset = 1'b1;
    nxt(); @(negedge clk);
    chk("rel_ready", 64'(fu_ready), 64'hF);
    chk("rel_valid", 64'(CDB_valid), 64'h0);

    // single result from port 1
    nxt(); drv(1, 7'h05, 32'hDEADBEEF, 1'b0, 1'b0);
    @(negedge clk); chk("single_c0_valid", 64'(CDB_valid), 64'h0);
    nxt(); fu_valid = '0;
    @(negedge clk); chk("single_c1_valid", 64'(CDB_valid), 64'h0);
    nxt(); @(negedge clk);
    chk("single_c2_valid", 64'(CDB_valid), 64'h1);
    chk("single_c2_tag", 64'(CDB_tag), 64'h05);
    chk("single_c2_data", 64'(CDB_data), 64'hDEADBEEF);
    nxt(); @(negedge clk); chk("single_c3_valid", 64'(CDB_valid), 64'h0);

    // round robin from rr_ptr = 0
    nxt(); reset = 1'b0;
    nxt(); reset = 1'b1;
    for (int i = 0; i < 4; i++) drv(i, 7'(7'h10 + i), 32'hA000_0000 + i, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) nxt();
      if (c == 1) fu_valid = '0;
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        chk("rr_valid", 64'(CDB_valid), 64'h1);
        chk("rr_tag", 64'(CDB_tag), 64'(7'h10 + c - 2));
      end else begin
        chk("rr_idle", 64'(CDB_valid), 64'h0);
      end
    end

    // backpressure: every port pushes every cycle
    lastp = 3;
    for (int i = 0; i < 4; i++) begin n[i] = 0; full[i] = 1'b0; end
    for (int k = 0; k < 20; k++) begin
      nxt();
      for (int i = 0; i < 4; i++) drv(i, {i[1:0], n[i][4:0]}, $urandom, 1'b0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (fu_ready[i] !== 1'b1) full[i] = 1'b1;
        else n[i]++;
      if (k >= 2) begin
        chk("bp_valid", 64'(CDB_valid), 64'h1);
        chk("bp_rr_port", 64'(CDB_tag[6:5]), 64'((lastp + 1) % 4));
        lastp = int'(CDB_tag[6:5]);
      end
    end
    nxt(); fu_valid = '0;
    repeat (12) nxt();
    for (int i = 0; i < 4; i++) begin
      chk("bp_saw_full", 64'(full[i]), 64'h1);
      chk("bp_drained", 64'(sb[i].size()), 64'h0);
    end

    // branch masking
    drv(3, 7'h12, 32'h0000_1234, 1'b1, 1'b1);
    nxt(); fu_valid = '0;
    nxt(); @(negedge clk);
    chk("br_valid", 64'(CDB_valid), 64'h1);
    chk("br_branch", 64'(CDB_branch), 64'h1);
    chk("br_taken", 64'(CDB_branch_taken), 64'h1);
    nxt(); drv(0, 7'h22, 32'h0000_5678, 1'b0, 1'b1);
    nxt(); fu_valid = '0;
    nxt(); @(negedge clk);
    chk("nb_valid", 64'(CDB_valid), 64'h1);
    chk("nb_branch", 64'(CDB_branch), 64'h0);
    chk("nb_taken", 64'(CDB_branch_taken), 64'h0);

    // flush with three buffers loaded; rr_ptr is 1 after the port-0 grant
    nxt();
    for (int i = 0; i < 3; i++) drv(i, 7'(7'h30 + i), 32'hB000_0000 + i, 1'b0, 1'b0);
    nxt();
    for (int i = 0; i < 3; i++) drv(i, 7'(7'h40 + i), 32'hC000_0000 + i, 1'b0, 1'b0);
    nxt();
    for (int i = 0; i < 4; i++) drv(i, 7'(7'h50 + i), 32'hD000_0000 + i, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_ready", 64'(fu_ready), 64'h0);
    chk("fl_cdb_valid", 64'(CDB_valid), 64'h1);
    chk("fl_cdb_tag", 64'(CDB_tag), 64'h31);
    nxt(); flush = 1'b0; fu_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("fl_idle", 64'(CDB_valid), 64'h0);
      nxt();
    end
    for (int i = 0; i < 4; i++) chk("end_sb_empty", 64'(sb[i].size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
